branch_predictor_f: RTL and testbench
=====================================

BRANCH_PREDICTOR_F -- requirements
Module: branch_predictor_f

Interface
REQ-001 Parameter ENTRIES, default 16, is the number of direct-mapped BTB entries and SHALL be a power of two (4..64).
REQ-002 iClk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 iRst  in  1  reset: one clock; reset is asynchronous and active-low. Asserted at 0; all state SHALL clear immediately.
REQ-004 iPCF  in  32  current fetch PC to predict.
REQ-005 iUpdateEn  in  1  resolved-branch update strobe from decode.
REQ-006 iUpdatePC  in  32  PC of the resolved branch.
REQ-007 iUpdateTaken  in  1  actual branch outcome.
REQ-008 iUpdateTarget  in  32  actual taken target.
REQ-009 iMispredict  in  1  the resolved branch was mispredicted; qualified by iUpdateEn.
REQ-010 iInvalidate  in  1  clear all entries.
REQ-011 oPCSrcF  out  1  predict taken; drives the fetch PC mux select.
REQ-012 oBranchTarget  out  32  predicted target; drives the fetch PC mux taken input.
REQ-013 oBranchCount  out  32  resolved-branch counter.
REQ-014 oMispredictCount  out  32  mispredict counter.

Function
REQ-015 Index SHALL be PC[log2(ENTRIES)+1:2]; tag SHALL be PC[31:log2(ENTRIES)+2]; PC[1:0] SHALL be ignored.
REQ-016 Each entry SHALL hold valid (1b), tag, target (32b) and a 2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-017 Lookup SHALL be combinational, with zero-cycle latency from iPCF: hit = valid && tag match.
REQ-018 oPCSrcF SHALL be hit && counter[1]; otherwise 0.
REQ-019 oBranchTarget SHALL be the entry target on a hit and 32'h0 on a miss.
REQ-020 When iUpdateEn=1 and the update index hits on tag, taken SHALL increment the counter (saturating at 11) and overwrite the target; not-taken SHALL decrement the counter (saturating at 00) and leave the target unchanged.
REQ-021 When iUpdateEn=1 and the update index misses (invalid or tag mismatch) with iUpdateTaken=1, the entry SHALL be allocated or replaced: valid=1, new tag, target=iUpdateTarget, counter=10.
REQ-022 A miss update with iUpdateTaken=0 SHALL leave the entry unchanged.
REQ-023 Updates SHALL take effect at the next rising edge; a lookup to the same index in the same cycle SHALL see pre-update state, with no bypass.
REQ-024 iInvalidate=1 SHALL clear every valid bit at the edge and SHALL take priority over a same-cycle update; counters and targets SHALL be left unchanged.
REQ-025 oBranchCount SHALL increment on every iUpdateEn=1 edge, including during iInvalidate.
REQ-026 oMispredictCount SHALL increment when iUpdateEn && iMispredict.
REQ-027 Both counters SHALL saturate at 32'hFFFFFFFF and SHALL NOT wrap.
REQ-028 iMispredict with iUpdateEn=0 SHALL be ignored.

Reset
REQ-029 While iRst=0, all valid bits SHALL be 0, all counters 01, all targets 32'h0, oBranchCount=0 and oMispredictCount=0; therefore oPCSrcF=0 and oBranchTarget=0.
REQ-030 Reset asserted mid-update SHALL discard the update; the first update edge after deassertion SHALL be honoured.

Verification
REQ-031 Reset, then sweep iPCF over 0x0..0x3C -> oPCSrcF=0 and oBranchTarget=0 for every value.
REQ-032 Update PC=0x100, taken, target=0x80 -> next cycle, iPCF=0x100 gives oPCSrcF=1 and oBranchTarget=0x80; iPCF=0x500 (same index, other tag) gives oPCSrcF=0.
REQ-033 Starting from the 0x100 entry at counter 10, apply not-taken twice -> oPCSrcF=0 (counter 00); then taken once -> oPCSrcF=0 (01); taken again -> oPCSrcF=1 (10).
REQ-034 Same-cycle update (PC=0x40, taken, target=0x10) with iPCF=0x40 -> oPCSrcF=0 that cycle and 1 the next; with iInvalidate=1 in the same cycle instead -> oPCSrcF stays 0 and oBranchCount still increments.
REQ-035 Preload oMispredictCount to 32'hFFFFFFFE via forced state or a long run, then apply 3 mispredicted updates -> the counter holds 32'hFFFFFFFF.
REQ-036 Drive iRst low asynchronously between clock edges after entries are allocated -> oPCSrcF=0 and both counts=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/branch_predictor_f_if.sv
// ============================================================================
// Module      : branch_predictor_f_if
// Description : Fetch-lookup, resolved-branch update and statistics signals
//               exchanged between the fetch/decode pipeline and the predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_predictor_f_if;
    logic [31:0] iPCF;
    logic        iUpdateEn;
    logic [31:0] iUpdatePC;
    logic        iUpdateTaken;
    logic [31:0] iUpdateTarget;
    logic        iMispredict;
    logic        iInvalidate;
    logic        oPCSrcF;
    logic [31:0] oBranchTarget;
    logic [31:0] oBranchCount;
    logic [31:0] oMispredictCount;

    modport master (
        output iPCF, iUpdateEn, iUpdatePC, iUpdateTaken, iUpdateTarget,
               iMispredict, iInvalidate,
        input  oPCSrcF, oBranchTarget, oBranchCount, oMispredictCount
    );

    modport slave (
        input  iPCF, iUpdateEn, iUpdatePC, iUpdateTaken, iUpdateTarget,
               iMispredict, iInvalidate,
        output oPCSrcF, oBranchTarget, oBranchCount, oMispredictCount
    );
endinterface

`default_nettype wire

// File: rtl/branch_predictor_f.sv
// ============================================================================
// Module      : branch_predictor_f
// Description : Direct-mapped BTB with 2-bit saturating direction counters,
//               combinational fetch lookup and saturating branch statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor_f #(
    parameter int ENTRIES = 16
) (
    input  wire logic             iClk,
    input  wire logic             iRst,
    branch_predictor_f_if.slave   bp
);

    localparam int          IDXW      = $clog2(ENTRIES);
    localparam int          TAGW      = 30 - IDXW;
    localparam logic [1:0]  c_CTR_RST = 2'b01;
    localparam logic [1:0]  c_CTR_NEW = 2'b10;
    localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

    logic              r_valid  [ENTRIES];
    logic [TAGW-1:0]   r_tag    [ENTRIES];
    logic [31:0]       r_target [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];
    logic [31:0]       r_branch_count;
    logic [31:0]       r_mispredict_count;

    logic [IDXW-1:0]   w_lk_idx;
    logic [TAGW-1:0]   w_lk_tag;
    logic              w_lk_hit;
    logic [IDXW-1:0]   w_up_idx;
    logic [TAGW-1:0]   w_up_tag;
    logic              w_up_hit;

    assign w_lk_idx = bp.iPCF[IDXW+1:2];
    assign w_lk_tag = bp.iPCF[31:IDXW+2];
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

    assign w_up_idx = bp.iUpdatePC[IDXW+1:2];
    assign w_up_tag = bp.iUpdatePC[31:IDXW+2];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    // Lookup reads the pre-edge table: no bypass from a same-cycle update.
    assign bp.oPCSrcF          = w_lk_hit && r_ctr[w_lk_idx][1];
    assign bp.oBranchTarget    = w_lk_hit ? r_target[w_lk_idx] : 32'h0;
    assign bp.oBranchCount     = r_branch_count;
    assign bp.oMispredictCount = r_mispredict_count;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= 32'h0;
                r_ctr[i]    <= c_CTR_RST;
            end
        end else if (bp.iInvalidate) begin
            // Only valid bits clear; counters and targets are retained.
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (bp.iUpdateEn) begin
            if (w_up_hit) begin
                if (bp.iUpdateTaken) begin
                    r_target[w_up_idx] <= bp.iUpdateTarget;
                    if (r_ctr[w_up_idx] != 2'b11) begin
                        r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'b01;
                    end
                end else if (r_ctr[w_up_idx] != 2'b00) begin
                    r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'b01;
                end
            end else if (bp.iUpdateTaken) begin
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= bp.iUpdateTarget;
                r_ctr[w_up_idx]    <= c_CTR_NEW;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_branch_count     <= 32'h0;
            r_mispredict_count <= 32'h0;
        end else if (bp.iUpdateEn) begin
            if (r_branch_count != c_CNT_MAX) begin
                r_branch_count <= r_branch_count + 32'h1;
            end
            if (bp.iMispredict && (r_mispredict_count != c_CNT_MAX)) begin
                r_mispredict_count <= r_mispredict_count + 32'h1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_f.sv
// ============================================================================
// Module      : tb_branch_predictor_f
// Description : Scoreboard bench for branch_predictor_f lookup, update,
//               invalidate, counter saturation and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor_f;

    typedef struct {
        logic        src;
        logic [31:0] tgt;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          n_total;
    int          n_bad;
    exp_t        q[$];
    logic [31:0] m_bc;
    logic [31:0] m_mc;

    branch_predictor_f_if bp ();

    branch_predictor_f #(.ENTRIES(16)) dut (
        .iClk (clk),
        .iRst (rst_n),
        .bp   (bp.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", t, obs, exp);
        end
    endtask

    task automatic sb_check(input string t);
        exp_t e;
        if (q.size() == 0) begin
            chk({t, ":empty"}, 32'h1, 32'h0);
        end else begin
            e = q.pop_front();
            chk({t, ":src"}, {31'h0, bp.oPCSrcF}, {31'h0, e.src});
            chk({t, ":tgt"}, bp.oBranchTarget, e.tgt);
            chk({t, ":bcnt"}, bp.oBranchCount, e.bc);
            chk({t, ":mcnt"}, bp.oMispredictCount, e.mc);
        end
    endtask

    task automatic cyc(input logic [31:0] pc, input logic en, input logic [31:0] upc,
                       input logic tk, input logic [31:0] utgt, input logic mis,
                       input logic inv, input logic e_src, input logic [31:0] e_tgt,
                       input string t);
        @(negedge clk);
        bp.iPCF          = pc;
        bp.iUpdateEn     = en;
        bp.iUpdatePC     = upc;
        bp.iUpdateTaken  = tk;
        bp.iUpdateTarget = utgt;
        bp.iMispredict   = mis;
        bp.iInvalidate   = inv;
        q.push_back('{e_src, e_tgt, m_bc, m_mc});
        #2;
        sb_check(t);
        if (en) begin
            if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 32'h1;
            if (mis && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 32'h1;
        end
    endtask

    task automatic look(input logic [31:0] pc, input logic e_src, input logic [31:0] e_tgt,
                        input string t);
        cyc(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, e_src, e_tgt, t);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        m_bc    = 32'h0;
        m_mc    = 32'h0;
        rst_n   = 1'b0;
        bp.iPCF = 32'h100; bp.iUpdateEn = 1'b0; bp.iUpdatePC = 32'h0;
        bp.iUpdateTaken = 1'b0; bp.iUpdateTarget = 32'h0;
        bp.iMispredict = 1'b0; bp.iInvalidate = 1'b0;
        #2;
        q.push_back('{1'b0, 32'h0, 32'h0, 32'h0});
        sb_check("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a <= 32'h3C; a += 4) begin
            look(a, 1'b0, 32'h0, "sweep");
        end

        // Allocate 0x100; same-cycle lookup still misses.
        cyc(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 32'h0, "alloc_same");
        look(32'h100, 1'b1, 32'h80, "alloc_hit");
        look(32'h500, 1'b0, 32'h0, "other_tag");

        // Counter walk 10 -> 01 -> 00 -> 01 -> 10.
        cyc(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h80, "nt1");
        cyc(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h80, "nt2");
        cyc(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 32'h80, "ctr00");
        cyc(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 32'h80, "ctr01");
        look(32'h100, 1'b1, 32'h80, "ctr10");

        // Mispredict without update strobe, and a not-taken miss, change nothing.
        cyc(32'h100, 1'b0, 32'h7C, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h80, "mis_noen");
        cyc(32'h7C, 1'b1, 32'h7C, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0, 32'h0, "nt_miss");
        look(32'h7C, 1'b0, 32'h0, "nt_miss_after");

        // Invalidate beats a same-cycle allocate; branch count still moves.
        cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 32'h0, "inv_same");
        look(32'h40, 1'b0, 32'h0, "inv_after");
        look(32'h100, 1'b0, 32'h0, "inv_cleared");

        cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, "upd_same");
        look(32'h40, 1'b1, 32'h10, "upd_next");
        cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 32'h10, "tgt_overwrite");
        cyc(32'h40, 1'b1, 32'h40, 1'b0, 32'h99, 1'b0, 1'b0, 1'b1, 32'h20, "nt_keep_tgt");
        look(32'h40, 1'b1, 32'h20, "ctr11_to_10");

        // Mispredict counter saturation from a preloaded value.
        @(negedge clk);
        force dut.r_mispredict_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_mispredict_count;
        m_mc = 32'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) begin
            cyc(32'h40, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h20, "mis_sat");
        end
        look(32'h40, 1'b1, 32'h20, "mis_sat_hold");

        // Asynchronous reset between edges.
        #1;
        rst_n = 1'b0;
        #1;
        m_bc = 32'h0;
        m_mc = 32'h0;
        q.push_back('{1'b0, 32'h0, 32'h0, 32'h0});
        sb_check("async_rst");

        // Update held across an edge in reset is dropped; first edge after release is taken.
        @(negedge clk);
        bp.iPCF = 32'h300; bp.iUpdateEn = 1'b1; bp.iUpdatePC = 32'h300;
        bp.iUpdateTaken = 1'b1; bp.iUpdateTarget = 32'h44; bp.iMispredict = 1'b0;
        bp.iInvalidate = 1'b0;
        q.push_back('{1'b0, 32'h0, 32'h0, 32'h0});
        #2;
        sb_check("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back('{1'b0, 32'h0, 32'h0, 32'h0});
        #2;
        sb_check("rst_release");
        m_bc = 32'h1;
        look(32'h300, 1'b1, 32'h44, "rst_first_upd");
        look(32'h40, 1'b0, 32'h0, "rst_cleared");

        chk("sb_drained", q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
